// File: rtl/tdm_pkg.sv
// Shared TDM definitions. The TX (8:1 mux) side uses the same slot numbering and defaults.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_e;

  localparam int TDM_NUM_CH = 8;
  localparam int TDM_SEL_W  = 3;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Mod-NUM_CH slot counter: clear wins over load-to-1, which wins over increment.
module tdm_slot_cnt #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load1_i,
  input  logic             clr_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             last_o
);

  logic [SEL_W-1:0] sel_q, sel_d;

  always_comb begin
    sel_d = sel_q;
    if (clr_i) begin
      sel_d = '0;
    end else if (load1_i) begin
      sel_d = SEL_W'(1);
    end else if (en_i) begin
      sel_d = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel_o  = sel_q;
  assign last_o = (sel_q == SEL_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux8_rx.sv
// TDM receiver: rebuilds NUM_CH slot-serial beats into one frame word with a
// single-entry valid/ready output buffer; capture never stalls on the consumer.
module tdm_demux8_rx
  import tdm_pkg::*;
#(
  parameter int NUM_CH = TDM_NUM_CH,
  parameter int SEL_W  = TDM_SEL_W,
  parameter int DATA_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        din_i,
  input  logic                     din_vld_i,
  input  logic                     sync_i,
  output logic [NUM_CH*DATA_W-1:0] frame_o,
  output logic                     frame_vld_o,
  input  logic                     frame_rdy_i,
  output logic [SEL_W-1:0]         sel_o,
  output logic                     locked_o,
  output logic                     sync_err_o,
  output logic                     ovf_o
);

  localparam int FRAME_W = NUM_CH * DATA_W;

  tdm_state_e         state_q, state_d;
  logic [FRAME_W-1:0] cap_q, cap_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               frame_vld_q, frame_vld_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;
  logic               cnt_en, cnt_ld, cnt_clr, wr_en, last;
  logic [SEL_W-1:0]   sel, wr_slot;

  tdm_slot_cnt #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_slot_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (cnt_en),
    .load1_i (cnt_ld),
    .clr_i   (cnt_clr),
    .sel_o   (sel),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_ld  = 1'b0;
    cnt_clr = 1'b0;
    wr_en   = 1'b0;
    wr_slot = sel;
    err_d   = 1'b0;
    done_d  = 1'b0;
    if (din_vld_i) begin
      case (state_q)
        HUNT: begin
          if (sync_i) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            cnt_ld  = 1'b1;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (sync_i) begin
            // Sync mid-frame restarts the frame here; the partial frame is simply overwritten.
            wr_en   = 1'b1;
            wr_slot = '0;
            cnt_ld  = 1'b1;
            err_d   = (sel != '0);
          end else if (sel == '0) begin
            cnt_clr = 1'b1;
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            wr_en   = 1'b1;
            cnt_en  = 1'b1;
            done_d  = last;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    cap_d = cap_q;
    if (wr_en) begin
      cap_d[int'(wr_slot)*DATA_W +: DATA_W] = din_i;
    end
  end

  // done_q marks cap_q as a complete frame; the next frame's slot-0 write lands on the same
  // edge the old contents are copied out, so back-to-back frames need no extra buffer.
  always_comb begin
    frame_d     = frame_q;
    frame_vld_d = frame_vld_q;
    ovf_d       = 1'b0;
    if (frame_vld_q && frame_rdy_i) begin
      frame_vld_d = 1'b0;
    end
    if (done_q) begin
      if (frame_vld_q && !frame_rdy_i) begin
        ovf_d = 1'b1;
      end else begin
        frame_d     = cap_q;
        frame_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cap_q       <= '0;
      frame_q     <= '0;
      frame_vld_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      frame_q     <= frame_d;
      frame_vld_q <= frame_vld_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign frame_o     = frame_q;
  assign frame_vld_o = frame_vld_q;
  assign sel_o       = sel;
  assign locked_o    = (state_q == LOCK);
  assign sync_err_o  = err_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_tdm_demux8_rx.sv
// Directed bench for tdm_demux8_rx: table of frames plus hand-written corner-case sequences.
module tb_tdm_demux8_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] din_i;
  logic       din_vld_i;
  logic       sync_i;
  logic [7:0] frame_o;
  logic       frame_vld_o;
  logic       frame_rdy_i;
  logic [2:0] sel_o;
  logic       locked_o;
  logic       sync_err_o;
  logic       ovf_o;

  int n_tests = 0;
  int n_fail  = 0;

  tdm_demux8_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_i       (din_i),
    .din_vld_i   (din_vld_i),
    .sync_i      (sync_i),
    .frame_o     (frame_o),
    .frame_vld_o (frame_vld_o),
    .frame_rdy_i (frame_rdy_i),
    .sel_o       (sel_o),
    .locked_o    (locked_o),
    .sync_err_o  (sync_err_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // beats: MSB is the slot-0 beat, LSB the slot-7 beat; exp is the frame word by hand.
  typedef struct {
    logic [7:0] beats;
    bit         gaps;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic d, input logic s);
    din_i     = d;
    sync_i    = s;
    din_vld_i = 1'b1;
    tick();
  endtask

  task automatic idle();
    din_vld_i = 1'b0;
    sync_i    = 1'b0;
    tick();
  endtask

  // Slot k carries w[k]; leaves din_vld_i low without advancing time.
  task automatic send_word(input logic [7:0] w);
    for (int k = 0; k < 8; k++) beat(w[k], k == 0);
    din_vld_i = 1'b0;
    sync_i    = 1'b0;
  endtask

  initial begin
    logic [7:0] w, prev_w;
    bit         err_seen;

    vecs[0] = '{8'b1011_0010, 1'b0, 8'h4D};
    vecs[1] = '{8'b1011_0010, 1'b1, 8'h4D};
    vecs[2] = '{8'b1000_0000, 1'b0, 8'h01};
    vecs[3] = '{8'b0000_0001, 1'b1, 8'h80};
    vecs[4] = '{8'b1111_0000, 1'b0, 8'h0F};
    vecs[5] = '{8'b0101_0101, 1'b1, 8'hAA};

    rst_n = 1'b0; din_i = 1'b0; din_vld_i = 1'b0; sync_i = 1'b0; frame_rdy_i = 1'b1;
    tick(); tick();
    chk("rst_frame", frame_o, 8'h00);
    chk("rst_vld", 8'(frame_vld_o), 8'h0);
    chk("rst_sel", 8'(sel_o), 8'h0);
    chk("rst_locked", 8'(locked_o), 8'h0);
    chk("rst_err", 8'(sync_err_o), 8'h0);
    chk("rst_ovf", 8'(ovf_o), 8'h0);
    rst_n = 1'b1;
    tick();

    // Beats before any sync are ignored
    for (int k = 0; k < 5; k++) beat(1'b1, 1'b0);
    din_vld_i = 1'b0;
    chk("hunt_locked", 8'(locked_o), 8'h0);
    chk("hunt_sel", 8'(sel_o), 8'h0);
    tick();
    chk("hunt_vld", 8'(frame_vld_o), 8'h0);

    foreach (vecs[i]) begin
      for (int k = 0; k < 8; k++) begin
        beat(vecs[i].beats[7-k], k == 0);
        if (vecs[i].gaps && k < 7) idle();
      end
      din_vld_i = 1'b0;
      sync_i    = 1'b0;
      chk($sformatf("v%0d_vld_early", i), 8'(frame_vld_o), 8'h0);
      chk($sformatf("v%0d_sel", i), 8'(sel_o), 8'h0);
      tick();
      chk($sformatf("v%0d_vld", i), 8'(frame_vld_o), 8'h1);
      chk($sformatf("v%0d_frame", i), frame_o, vecs[i].exp);
      chk($sformatf("v%0d_locked", i), 8'(locked_o), 8'h1);
    end
    tick();
    chk("vld_cleared", 8'(frame_vld_o), 8'h0);

    // Sync arriving at slot 4: resync
    for (int k = 0; k < 4; k++) beat(1'b1, k == 0);
    beat(1'b0, 1'b1);
    chk("resync_err", 8'(sync_err_o), 8'h1);
    chk("resync_sel", 8'(sel_o), 8'h1);
    chk("resync_locked", 8'(locked_o), 8'h1);
    w = 8'h5A;
    for (int k = 1; k < 8; k++) begin
      beat(w[k], 1'b0);
      if (k == 1) chk("resync_err_pulse", 8'(sync_err_o), 8'h0);
    end
    din_vld_i = 1'b0;
    tick();
    chk("resync_frame", frame_o, 8'h5A);
    chk("resync_vld", 8'(frame_vld_o), 8'h1);

    // Missing sync at slot 0: back to HUNT
    beat(1'b0, 1'b0);
    chk("nosync_err", 8'(sync_err_o), 8'h1);
    chk("nosync_locked", 8'(locked_o), 8'h0);
    chk("nosync_sel", 8'(sel_o), 8'h0);
    beat(1'b1, 1'b0);
    chk("nosync_err_pulse", 8'(sync_err_o), 8'h0);
    chk("nosync_hunt", 8'(locked_o), 8'h0);
    chk("nosync_hunt_sel", 8'(sel_o), 8'h0);
    send_word(8'hC3);
    tick();
    chk("relock_frame", frame_o, 8'hC3);
    chk("relock_locked", 8'(locked_o), 8'h1);
    tick();

    // Overflow with consumer stalled
    frame_rdy_i = 1'b0;
    send_word(8'hA5);
    tick();
    chk("ovfA_frame", frame_o, 8'hA5);
    chk("ovfA_vld", 8'(frame_vld_o), 8'h1);
    send_word(8'h3C);
    tick();
    chk("ovf_pulse", 8'(ovf_o), 8'h1);
    chk("ovf_hold", frame_o, 8'hA5);
    chk("ovf_vld", 8'(frame_vld_o), 8'h1);
    tick();
    chk("ovf_pulse_end", 8'(ovf_o), 8'h0);
    frame_rdy_i = 1'b1;
    tick();
    chk("ovf_drain", 8'(frame_vld_o), 8'h0);
    send_word(8'hF0);
    tick();
    chk("ovfC_frame", frame_o, 8'hF0);
    chk("ovfC_ovf", 8'(ovf_o), 8'h0);
    tick();

    // Back-to-back frames, ready raised exactly at second completion
    frame_rdy_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      w = (k < 8) ? 8'h96 : 8'h69;
      beat(w[k%8], (k % 8) == 0);
      if (k == 8) begin
        chk("b2b_first", frame_o, 8'h96);
        chk("b2b_first_vld", 8'(frame_vld_o), 8'h1);
      end
    end
    din_vld_i = 1'b0;
    sync_i    = 1'b0;
    frame_rdy_i = 1'b1;
    tick();
    chk("b2b_second", frame_o, 8'h69);
    chk("b2b_vld", 8'(frame_vld_o), 8'h1);
    chk("b2b_no_ovf", 8'(ovf_o), 8'h0);
    frame_rdy_i = 1'b0;

    // Reset asserted at slot 5 with a held frame
    w = 8'h77;
    for (int k = 0; k < 5; k++) beat(w[k], k == 0);
    din_i = w[5];
    rst_n = 1'b0;
    #1;
    chk("mrst_frame", frame_o, 8'h00);
    chk("mrst_vld", 8'(frame_vld_o), 8'h0);
    chk("mrst_sel", 8'(sel_o), 8'h0);
    chk("mrst_locked", 8'(locked_o), 8'h0);
    tick();
    rst_n = 1'b1;
    din_vld_i = 1'b0;
    tick();
    beat(1'b1, 1'b0);
    din_vld_i = 1'b0;
    chk("mrst_hunt", 8'(locked_o), 8'h0);
    chk("mrst_hunt_sel", 8'(sel_o), 8'h0);

    // Loopback from an 8:1 mux model, continuous frames
    frame_rdy_i = 1'b1;
    err_seen = 1'b0;
    prev_w = 8'h00;
    for (int f = 0; f < 1000; f++) begin
      w = 8'(f * 37 + 5);
      for (int s = 0; s < 8; s++) begin
        beat(w[s], s == 0);
        if (sync_err_o || ovf_o) err_seen = 1'b1;
        if (s == 0 && f > 0) chk($sformatf("loop_f%0d", f - 1), frame_o, prev_w);
      end
      prev_w = w;
    end
    din_vld_i = 1'b0;
    sync_i    = 1'b0;
    tick();
    chk("loop_last", frame_o, prev_w);
    chk("loop_no_err", 8'(err_seen), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
